// File: rtl/mmu_req_rx_buffer.sv
// Slave-side receive buffer for MMU access requests: in-order FIFO with
// registered back-pressure, re-presented downstream over valid/ready.
module mmu_req_rx_buffer #(
  parameter int XLEN   = 64,
  parameter int USER_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk_i,
  input  logic                       arst_i,
  input  logic [7:0]                 slv_id_i,
  input  logic [XLEN-1:0]            slv_addr_i,
  input  logic [XLEN-1:0]            slv_data_i,
  input  logic [4:0]                 slv_opcode_i,
  input  logic [9:0]                 slv_funct_i,
  input  logic [USER_W-1:0]          slv_user_i,
  input  logic                       slv_valid_i,
  output logic                       slv_full_o,
  input  logic                       flush_i,
  output logic [7:0]                 req_id_o,
  output logic [XLEN-1:0]            req_addr_o,
  output logic [XLEN-1:0]            req_data_o,
  output logic [4:0]                 req_opcode_o,
  output logic [9:0]                 req_funct_o,
  output logic [USER_W-1:0]          req_user_o,
  output logic                       req_valid_o,
  input  logic                       req_ready_i,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [7:0]        id;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   data;
    logic [4:0]        opcode;
    logic [9:0]        funct;
    logic [USER_W-1:0] user;
  } req_t;

  req_t        mem [DEPTH];
  req_t        head;
  logic [AW:0] wptr, rptr;
  logic        push, pop;

  // Full/empty come only from registered pointers; MSB is the wrap flag.
  assign count_o     = wptr - rptr;
  assign slv_full_o  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign req_valid_o = (wptr != rptr);

  assign push = slv_valid_i && !slv_full_o && !flush_i;
  assign pop  = req_valid_o && req_ready_i && !flush_i;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush_i) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage is not reset; valid gating keeps stale entries invisible.
  always_ff @(posedge clk_i) begin
    if (push)
      mem[wptr[AW-1:0]] <= '{id: slv_id_i, addr: slv_addr_i, data: slv_data_i,
                             opcode: slv_opcode_i, funct: slv_funct_i,
                             user: slv_user_i};
  end

  assign head         = mem[rptr[AW-1:0]];
  assign req_id_o     = head.id;
  assign req_addr_o   = head.addr;
  assign req_data_o   = head.data;
  assign req_opcode_o = head.opcode;
  assign req_funct_o  = head.funct;
  assign req_user_o   = head.user;
endmodule

// File: tb/tb_mmu_req_rx_buffer.sv
// Randomized + directed bench for mmu_req_rx_buffer against a queue model.
module tb_mmu_req_rx_buffer;
  localparam int XLEN = 64, USER_W = 8, DEPTH = 4;
  localparam int RW = 8 + XLEN + XLEN + 5 + 10 + USER_W;

  typedef struct packed {
    logic [7:0]        id;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   data;
    logic [4:0]        opcode;
    logic [9:0]        funct;
    logic [USER_W-1:0] user;
  } req_t;

  logic              clk = 0, arst = 1;
  logic [7:0]        slv_id = '0;
  logic [XLEN-1:0]   slv_addr = '0, slv_data = '0;
  logic [4:0]        slv_opcode = '0;
  logic [9:0]        slv_funct = '0;
  logic [USER_W-1:0] slv_user = '0;
  logic              slv_valid = 0, slv_full, flush = 0;
  logic [7:0]        req_id;
  logic [XLEN-1:0]   req_addr, req_data;
  logic [4:0]        req_opcode;
  logic [9:0]        req_funct;
  logic [USER_W-1:0] req_user;
  logic              req_valid, req_ready = 0;
  logic [2:0]        count;

  int checks = 0, errors = 0;
  req_t q[$];

  always #5 clk = ~clk;

  mmu_req_rx_buffer #(.XLEN(XLEN), .USER_W(USER_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .arst_i(arst),
    .slv_id_i(slv_id), .slv_addr_i(slv_addr), .slv_data_i(slv_data),
    .slv_opcode_i(slv_opcode), .slv_funct_i(slv_funct), .slv_user_i(slv_user),
    .slv_valid_i(slv_valid), .slv_full_o(slv_full), .flush_i(flush),
    .req_id_o(req_id), .req_addr_o(req_addr), .req_data_o(req_data),
    .req_opcode_o(req_opcode), .req_funct_o(req_funct), .req_user_o(req_user),
    .req_valid_o(req_valid), .req_ready_i(req_ready), .count_o(count)
  );

  task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic req_t head_now();
    return '{id: req_id, addr: req_addr, data: req_data, opcode: req_opcode,
             funct: req_funct, user: req_user};
  endfunction

  task automatic check_outs();
    chk("count", RW'(count), RW'(q.size()));
    chk("valid", RW'(req_valid), RW'(q.size() != 0));
    chk("full", RW'(slv_full), RW'(q.size() == DEPTH));
    if (q.size() != 0) chk("head", RW'(head_now()), RW'(q[0]));
  endtask

  // One clock: check at negedge, advance model by the rules, return at posedge+1.
  task automatic cycle();
    req_t in;
    bit   pu, po;
    @(negedge clk);
    check_outs();
    in = '{id: slv_id, addr: slv_addr, data: slv_data, opcode: slv_opcode,
           funct: slv_funct, user: slv_user};
    pu = slv_valid && q.size() < DEPTH && !flush;
    po = q.size() != 0 && req_ready && !flush;
    if (flush) q.delete();
    else begin
      if (po) void'(q.pop_front());
      if (pu) q.push_back(in);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [7:0] id);
    slv_valid  = v;
    slv_id     = id;
    slv_addr   = {$urandom, $urandom};
    slv_data   = {$urandom, $urandom};
    slv_opcode = 5'($urandom);
    slv_funct  = 10'($urandom);
    slv_user   = 8'($urandom);
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_count", RW'(count), '0);
    chk("rst_valid", RW'(req_valid), '0);
    chk("rst_full", RW'(slv_full), '0);
    arst = 0;
    @(posedge clk); #1;

    // single request
    drive(1, 8'h12); slv_addr = 64'h8000_1000; slv_opcode = 5'h03; req_ready = 1;
    cycle();
    drive(0, 8'h00);
    chk("single_id", RW'(req_id), RW'(8'h12));
    chk("single_addr", RW'(req_addr), RW'(64'h8000_1000));
    chk("single_cnt", RW'(count), RW'(1));
    cycle();
    chk("single_cnt0", RW'(count), '0);

    // fill past depth
    req_ready = 0;
    for (int i = 1; i <= 5; i++) begin drive(1, 8'(i)); cycle(); end
    drive(0, 8'h00);
    chk("fill_full", RW'(slv_full), RW'(1));
    chk("fill_cnt", RW'(count), RW'(4));
    req_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_id", RW'(req_id), RW'(i));
      cycle();
    end
    chk("drain_empty", RW'(req_valid), '0);

    // simultaneous push/pop at count 2
    req_ready = 0;
    drive(1, 8'h21); cycle();
    drive(1, 8'h22); cycle();
    req_ready = 1; drive(1, 8'h23); cycle();
    chk("simul_cnt", RW'(count), RW'(2));
    chk("simul_head", RW'(req_id), RW'(8'h22));
    for (int i = 0; i < 20; i++) begin drive(1, 8'(8'h40 + i)); cycle(); end
    drive(0, 8'h00);
    repeat (4) cycle();

    // full release timing
    req_ready = 0;
    for (int i = 0; i < 4; i++) begin drive(1, 8'(8'h50 + i)); cycle(); end
    req_ready = 1; drive(1, 8'h55);
    chk("rel_full_n", RW'(slv_full), RW'(1));
    cycle();
    chk("rel_full_n1", RW'(slv_full), '0);
    chk("rel_cnt_n1", RW'(count), RW'(3));
    req_ready = 0;
    cycle();
    drive(0, 8'h00);
    chk("rel_cnt", RW'(count), RW'(4));
    req_ready = 1;
    repeat (4) cycle();
    // 0x55 is last, must have come out (model checked head along the way)

    // flush with simultaneous push and pop
    req_ready = 0;
    for (int i = 0; i < 3; i++) begin drive(1, 8'(8'h60 + i)); cycle(); end
    flush = 1; req_ready = 1; drive(1, 8'h66);
    cycle();
    flush = 0; drive(0, 8'h00);
    chk("flush_cnt", RW'(count), '0);
    chk("flush_valid", RW'(req_valid), '0);
    chk("flush_full", RW'(slv_full), '0);
    cycle();
    chk("flush_novalid", RW'(req_valid), '0);

    // async reset mid-stream
    req_ready = 0;
    drive(1, 8'h71); cycle();
    drive(1, 8'h72); cycle();
    drive(0, 8'h00);
    chk("pre_rst_cnt", RW'(count), RW'(2));
    #1 arst = 1;
    #1;
    chk("arst_cnt", RW'(count), '0);
    chk("arst_valid", RW'(req_valid), '0);
    chk("arst_full", RW'(slv_full), '0);
    q.delete();
    #1 arst = 0;
    drive(1, 8'h07); cycle();
    drive(0, 8'h00);
    chk("post_rst_id", RW'(req_id), RW'(8'h07));
    req_ready = 1; cycle();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, 8'($urandom));
      req_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 32) == 0;
      cycle();
    end
    flush = 0; drive(0, 8'h00); req_ready = 1;
    repeat (6) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mmu_req_rx_buffer.md
Name: mmu_req_rx_buffer

Overview:
- Receiving end of the MMU access request channel. Acts as the slave side: it samples id/addr/data/opcode/funct/user on valid and back-pressures the master with full.
- Requests are queued in a small in-order FIFO and re-presented to the TLB/page-walk pipeline over a valid/ready handshake.
- A flush input discards all queued requests on pipeline redirect.

Parameters:
- XLEN, 64, address/data width.
- USER_W, 8, width of the user sideband (MMU_USER_W).
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk_i  in  1  clock.
- arst_i  in  1  asynchronous reset, active-high.
- slv_id_i  in  8  request id.
- slv_addr_i  in  XLEN  request address.
- slv_data_i  in  XLEN  request data.
- slv_opcode_i  in  5  request opcode.
- slv_funct_i  in  10  request function.
- slv_user_i  in  USER_W  user sideband.
- slv_valid_i  in  1  request valid.
- slv_full_o  out  1  back-pressure to the master.
- flush_i  in  1  discard all queued and incoming requests.
- req_id_o  out  8  head entry id.
- req_addr_o  out  XLEN  head entry address.
- req_data_o  out  XLEN  head entry data.
- req_opcode_o  out  5  head entry opcode.
- req_funct_o  out  10  head entry function.
- req_user_o  out  USER_W  head entry user sideband.
- req_valid_o  out  1  head entry valid.
- req_ready_i  in  1  downstream accepts the head entry.
- count_o  out  log2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: DEPTH-entry circular buffer.
  - Write pointer and read pointer are each log2(DEPTH)+1 bits, with the MSB used as the wrap flag.
  - count = wptr - rptr.
  - Full condition: pointers differ only in the MSB. Empty condition: pointers are equal.
- Push: occurs when slv_valid_i=1 and slv_full_o=0 and flush_i=0. All six fields are written at the wptr index, and wptr increments.
- slv_full_o: equals (count==DEPTH), derived from registered pointers only. It has no combinational path from slv_valid_i or req_ready_i.
  - A pop in a cycle does not clear full in that same cycle; full deasserts the following cycle.
  - Fixed rule: a master seeing full=1 holds its request and retries.
- Pop: occurs when req_valid_o=1 and req_ready_i=1 and flush_i=0. rptr increments.
- req_valid_o: equals (count!=0). req_*_o present the entry at rptr directly from storage, with zero added latency beyond the write cycle.
- Minimum latency: a request pushed in cycle N appears on req_valid_o in cycle N+1.
- Throughput: one push and one pop per cycle sustained when neither full nor empty.
- Simultaneous push and pop: both occur and count is unchanged.
- Push when count==DEPTH: blocked by full, and no entry is overwritten. Any slv_valid_i while full is ignored.
- Pop when empty: req_valid_o=0, so a high req_ready_i has no effect.
- Wrap-around: pointer index uses the low log2(DEPTH) bits. FIFO order is preserved across the wrap.
- flush_i=1:
  - Next cycle wptr=rptr=0 and count=0.
  - Any push or pop in the flush cycle is discarded.
  - req_valid_o and slv_full_o are 0 from the next cycle.
- Reset (arst_i=1, asynchronous, at any time including mid-transfer):
  - Pointers go to 0.
  - slv_full_o=0, req_valid_o=0, count_o=0.
  - Storage contents are not reset; req_*_o data fields are don't-care while req_valid_o=0.
- req_valid_o is never asserted from stale storage. Data fields are only defined while req_valid_o=1.

Test Plan:
- Single request: after reset, push id=0x12, addr=0x8000_1000, opcode=5'h03, with req_ready_i=1.
  - req_valid_o=1 the next cycle with identical fields, count_o 1->0.
- Fill: DEPTH=4, req_ready_i=0, push ids 1..5 on consecutive cycles.
  - slv_full_o rises after the 4th push; id 5 is not stored; count_o=4.
  - Draining yields ids 1,2,3,4 in order.
- Simultaneous push/pop at count=2: one push and one pop in the same cycle.
  - count_o stays 2 and the output order is intact.
  - Stream 20 back-to-back requests with req_ready_i=1 to exercise pointer wrap: all 20 ids come out in order.
- Full release timing: at count=4, pop in cycle N.
  - slv_full_o is still 1 in cycle N and 0 in N+1.
  - A push presented in N is not accepted; the same push held into N+1 is accepted.
- Flush: with count=3, assert flush_i together with a valid push and ready=1.
  - Next cycle count_o=0, req_valid_o=0, slv_full_o=0, and the pushed id never appears.
- Async reset mid-stream: assert arst_i between clock edges while count=2.
  - Outputs go to 0 immediately.
  - After release, a new push of id=0x7 appears first at the output.
